// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, frame constants and parity helper.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_EDGES = 11;
  localparam int unsigned PS2_EDGE_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_REL
  } ps2_tx_state_e;

  // Parity bit that makes the total number of ones (data + parity) odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a clock falling-edge detector.
module ps2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_s,
  output logic data_s,
  output logic fall_c
);

  logic clk_m;
  logic data_m;
  logic clk_p;

  // Idle bus level is high, so reset to 1 to avoid a false fall after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_m  <= 1'b1;
      clk_s  <= 1'b1;
      clk_p  <= 1'b1;
      data_m <= 1'b1;
      data_s <= 1'b1;
    end else begin
      clk_m  <= ps2_clk_in;
      clk_s  <= clk_m;
      clk_p  <= clk_s;
      data_m <= ps2_data_in;
      data_s <= data_m;
    end
  end

  assign fall_c = clk_p & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, request-to-send, 10 bits out, ACK sample).
// Optional abort timeout from RTS entry is enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CYC_PER_US  = CLK_HZ / 1_000_000;
  localparam int unsigned INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
  localparam int unsigned TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;
  // One counter serves the inhibit phase and, later in the frame, the timeout.
  localparam int unsigned CNT_MAX     = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);

  ps2_tx_state_e          state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [PS2_EDGE_W-1:0]  edges, edges_nx;
  logic [9:0]             frame, frame_nx;
  logic                   data_oe_nx;
  logic                   done_nx;
  logic                   err_nx;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall_c;

  ps2_edge_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_s       (clk_s),
    .data_s      (data_s),
    .fall_c      (fall_c)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      edges       <= '0;
      frame       <= '0;
      tx_ready    <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      edges       <= edges_nx;
      frame       <= frame_nx;
      tx_ready    <= (state_nx == IDLE);
      tx_done     <= done_nx;
      tx_err      <= err_nx;
      ps2_clk_oe  <= (state_nx == INHIBIT);
      ps2_data_oe <= data_oe_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    edges_nx   = edges;
    frame_nx   = frame;
    data_oe_nx = ps2_data_oe;
    done_nx    = 1'b0;
    err_nx     = 1'b0;

    unique case (state)
      IDLE: begin
        data_oe_nx = 1'b0;
        if (tx_valid && tx_ready) begin
          state_nx = INHIBIT;
          cnt_nx   = '0;
          edges_nx = '0;
          frame_nx = {1'b1, odd_parity(tx_data), tx_data};
        end
      end
      INHIBIT: begin
        if (cnt == CNT_W'(INHIBIT_CYC - 1)) begin
          state_nx   = RTS;
          cnt_nx     = '0;
          data_oe_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      // Frame holds data LSB first, then parity, then a 1 that releases the line as stop bit.
      RTS, SHIFT: begin
        if (fall_c) begin
          edges_nx   = edges + PS2_EDGE_W'(1);
          data_oe_nx = ~frame[0];
          frame_nx   = {1'b0, frame[9:1]};
          state_nx   = (edges_nx == PS2_EDGE_W'(PS2_FRAME_EDGES - 1)) ? ACK : SHIFT;
        end
      end
      ACK: begin
        if (fall_c) begin
          state_nx = WAIT_REL;
          done_nx  = ~data_s;
          err_nx   = data_s;
        end
      end
      WAIT_REL: begin
        if (clk_s && data_s) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // An ACK completing on the same cycle as expiry wins over the timeout.
    if ((state inside {RTS, SHIFT, ACK}) && (state_nx != WAIT_REL)) begin
      if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
        state_nx   = IDLE;
        data_oe_nx = 1'b0;
        done_nx    = 1'b0;
        err_nx     = 1'b1;
      end else begin
        cnt_nx = cnt + CNT_W'(1);
      end
    end
`endif
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model (40-cycle clock period).
module tb_ps2_host_tx;

  localparam int unsigned HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int checks = 0;
  int passed = 0;

  int acc_cnt = 0, done_cnt = 0, err_cnt = 0, done_hi = 0, err_hi = 0, both_cnt = 0;
  logic done_q = 1'b0, err_q = 1'b0;

  always #5 clk = ~clk;

  // Wired-AND open-drain lines.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_HZ     (1_000_000),
    .INHIBIT_US (100),
    .TIMEOUT_US (15000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  // Observer: accepted bytes and pulse counts/widths, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
    if (tx_done) done_hi <= done_hi + 1;
    if (tx_err) err_hi <= err_hi + 1;
    if (tx_done && !done_q) done_cnt <= done_cnt + 1;
    if (tx_err && !err_q) err_cnt <= err_cnt + 1;
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    done_q <= tx_done;
    err_q  <= tx_err;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected line levels after falls 1..10: data LSB first, odd parity, stop.
  function automatic logic [10:1] exp_frame(input logic [7:0] b);
    logic [10:1] f;
    for (int i = 1; i <= 8; i++) f[i] = b[i-1];
    f[9]  = (($countones(b) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_byte(input logic [7:0] b);
    int k;
    k = 0;
    while (tx_ready !== 1'b1 && k < 500) begin tick; k++; end
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL ready_wait: tx_ready=%b want 1", tx_ready);
    else passed++;
    tx_data  = b;
    tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    checks++;
    if (tx_ready !== 1'b0) $display("FAIL ready_drop: tx_ready=%b want 0", tx_ready);
    else passed++;
  endtask

  // Device side of one host-to-device frame; optionally stops after a given edge.
  task automatic device(input logic [7:0] b, input bit ack, input int abort_edge, output bit aborted);
    int k;
    logic [10:1] bits;
    aborted = 1'b0;
    bits = '0;
    k = 0;
    while (ps2_clk_oe !== 1'b1 && k < 1000) begin tick; k++; end
    k = 0;
    while (ps2_clk_oe === 1'b1 && k < 1000) begin k++; tick; end
    checks++;
    if (k != 100) $display("FAIL inhibit_len: got %0d cycles want 100", k);
    else passed++;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) $display("FAIL start_bit: clk_oe,data_oe=%b want 01", {ps2_clk_oe, ps2_data_oe});
    else passed++;
    repeat (10) tick;
    for (int n = 1; n <= 11; n++) begin
      dev_clk = 1'b0;
      repeat (HALF) tick;
      if (n <= 10) bits[n] = ps2_data_in;
      if (n == 11) begin
        checks++;
        if (tx_ready !== 1'b0) $display("FAIL wait_rel_clk_low: tx_ready=%b want 0", tx_ready);
        else passed++;
      end
      dev_clk = 1'b1;
      if (n == 10 && ack) dev_data = 1'b0;
      if (n == abort_edge) begin
        aborted = 1'b1;
        break;
      end
      repeat (HALF) tick;
    end
    if (!aborted) begin
      checks++;
      if (bits !== exp_frame(b)) $display("FAIL frame_bits byte=%02h: got %b want %b", b, bits, exp_frame(b));
      else passed++;
      if (ack) begin
        checks++;
        if (tx_ready !== 1'b0) $display("FAIL wait_rel_data_low: tx_ready=%b want 0", tx_ready);
        else passed++;
      end
      dev_data = 1'b1;
      k = 0;
      while (tx_ready !== 1'b1 && k < 10) begin tick; k++; end
      checks++;
      if (tx_ready !== 1'b1) $display("FAIL release_ready: tx_ready=%b want 1", tx_ready);
      else passed++;
    end
  endtask

  task automatic send_and_check(input logic [7:0] b, input bit ack);
    int d0, e0, a0;
    bit ab;
    d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
    start_byte(b);
    device(b, ack, 0, ab);
    checks++;
    if (done_cnt - d0 != (ack ? 1 : 0)) $display("FAIL done_count byte=%02h: got %0d want %0d", b, done_cnt - d0, ack ? 1 : 0);
    else passed++;
    checks++;
    if (err_cnt - e0 != (ack ? 0 : 1)) $display("FAIL err_count byte=%02h: got %0d want %0d", b, err_cnt - e0, ack ? 0 : 1);
    else passed++;
    checks++;
    if (acc_cnt - a0 != 1) $display("FAIL accept_count byte=%02h: got %0d want 1", b, acc_cnt - a0);
    else passed++;
  endtask

  task automatic test_reset;
    repeat (3) tick;
    checks++;
    if ({tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_data_oe} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000", {tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_data_oe});
    else passed++;
    rst = 1'b1;
    tick;
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL reset_release_ready: tx_ready=%b want 1", tx_ready);
    else passed++;
  endtask

  task automatic test_known_bytes;
    send_and_check(8'hED, 1'b1);
    send_and_check(8'h00, 1'b1);
    send_and_check(8'h01, 1'b1);
  endtask

  task automatic test_nack;
    send_and_check(8'h3C, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++) send_and_check(8'($urandom), ($urandom_range(0, 3) != 0));
  endtask

  task automatic test_reset_mid;
    int d0, e0;
    bit ab;
    start_byte(8'hE4);
    device(8'hE4, 1'b1, 5, ab);
    checks++;
    if (ps2_data_oe !== 1'b1) $display("FAIL pre_reset_data_oe: got %b want 1", ps2_data_oe);
    else passed++;
    d0 = done_cnt; e0 = err_cnt;
    rst = 1'b0;
    tick;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b000)
      $display("FAIL reset_mid_release: clk_oe,data_oe,ready=%b want 000", {ps2_clk_oe, ps2_data_oe, tx_ready});
    else passed++;
    repeat (5) tick;
    checks++;
    if ((done_cnt != d0) || (err_cnt != e0)) $display("FAIL reset_mid_pulses: done+%0d err+%0d want 0", done_cnt - d0, err_cnt - e0);
    else passed++;
    rst = 1'b1;
    tick;
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL reset_mid_ready: tx_ready=%b want 1", tx_ready);
    else passed++;
    send_and_check(8'hF4, 1'b1);
  endtask

  task automatic test_valid_fall;
    int d0, a0;
    bit ab;
    d0 = done_cnt; a0 = acc_cnt;
    dev_clk = 1'b0;
    tick;
    tick;
    tx_data  = 8'hA7;
    tx_valid = 1'b1;
    tick;
    dev_clk = 1'b1;
    fork
      device(8'hA7, 1'b1, 0, ab);
      begin
        int k;
        k = 0;
        while (tx_done !== 1'b1 && k < 5000) begin tick; k++; end
        tx_valid = 1'b0;
      end
    join
    checks++;
    if (acc_cnt - a0 != 1) $display("FAIL held_valid_accepts: got %0d want 1", acc_cnt - a0);
    else passed++;
    checks++;
    if (done_cnt - d0 != 1) $display("FAIL held_valid_done: got %0d want 1", done_cnt - d0);
    else passed++;
  endtask

`ifdef PS2_TX_TIMEOUT_EN
  task automatic test_timeout;
    int k, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    start_byte(8'h55);
    k = 0;
    while (ps2_clk_oe === 1'b1 && k < 1000) begin tick; k++; end
    k = 0;
    while (tx_err !== 1'b1 && k < 20000) begin tick; k++; end
    checks++;
    if (k != 15000) $display("FAIL timeout_latency: got %0d cycles want 15000", k);
    else passed++;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL timeout_release: clk_oe,data_oe=%b want 00", {ps2_clk_oe, ps2_data_oe});
    else passed++;
    tick;
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL timeout_ready: tx_ready=%b want 1", tx_ready);
    else passed++;
    checks++;
    if ((err_cnt - e0 != 1) || (done_cnt != d0)) $display("FAIL timeout_pulses: err+%0d done+%0d want 1/0", err_cnt - e0, done_cnt - d0);
    else passed++;
  endtask
`endif

  task automatic test_pulses;
    checks++;
    if (both_cnt != 0) $display("FAIL done_err_overlap: got %0d cycles want 0", both_cnt);
    else passed++;
    checks++;
    if (done_hi != done_cnt) $display("FAIL done_width: high cycles %0d pulses %0d want equal", done_hi, done_cnt);
    else passed++;
    checks++;
    if (err_hi != err_cnt) $display("FAIL err_width: high cycles %0d pulses %0d want equal", err_hi, err_cnt);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_known_bytes;
    test_nack;
    test_random;
    test_reset_mid;
    test_valid_fall;
`ifdef PS2_TX_TIMEOUT_EN
    test_timeout;
`endif
    test_pulses;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- INHIBIT_US, 100, length of the clock-inhibit phase in microseconds.
- TIMEOUT_US, 15000, abort limit in microseconds, measured from the start of the request-to-send phase.
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk, input, 1, single system clock; all logic is on its rising edge.
- rst, input, 1, synchronous, active-low reset.
- tx_data, input, 8, command byte to send to the keyboard.
- tx_valid, input, 1, tx_data is valid.
- tx_ready, output, 1, block is idle and can accept a byte.
- tx_done, output, 1, one-cycle pulse: byte sent and acknowledged by the device.
- tx_err, output, 1, one-cycle pulse: device returned NACK, or a timeout occurred.
- ps2_clk_in, input, 1, raw level of the PS/2 clock line (asynchronous).
- ps2_data_in, input, 1, raw level of the PS/2 data line (asynchronous).
- ps2_clk_oe, output, 1, 1 = pull the PS/2 clock line low; 0 = release it.
- ps2_data_oe, output, 1, 1 = pull the PS/2 data line low; 0 = release it.

Function
REQ-003 ps2_clk_in and ps2_data_in SHALL each pass through a 2-flop synchronizer.
REQ-004 A PS/2 clock falling edge (fall) SHALL be a one-cycle pulse when the previous synchronized clock is 1 and the current one is 0.
REQ-005 A byte SHALL be accepted on a cycle with tx_valid=1 and tx_ready=1; tx_data SHALL be captured on that cycle and tx_ready SHALL be 0 on the next cycle.
REQ-006 The state machine SHALL have the states IDLE, INHIBIT, RTS, SHIFT, ACK and WAIT_REL.
REQ-007 IDLE: tx_ready=1, both oe=0, and falls are ignored; an accepted byte SHALL move the state to INHIBIT.
REQ-008 INHIBIT: ps2_clk_oe=1 for exactly CLK_HZ/1_000_000*INHIBIT_US cycles; the state SHALL then move to RTS.
REQ-009 RTS: ps2_data_oe=1 (start bit) and ps2_clk_oe=0; the first fall SHALL move the state to SHIFT with the edge count at 1.
REQ-010 SHIFT: on the cycle after fall n, ps2_data_oe SHALL be set to the inverse of the bit being sent:
- n=1..8: data bit n-1, LSB first.
- n=9: odd parity over the 8 data bits.
- n=10: the line is released (stop bit), and the state moves to ACK.
REQ-011 ACK: on the next fall, a synchronized data level of 0 SHALL cause a tx_done pulse and a synchronized level of 1 SHALL cause a tx_err pulse; in both cases the state SHALL move to WAIT_REL.
REQ-012 WAIT_REL: the state SHALL move to IDLE once the synchronized clock and data are both 1.
REQ-013 tx_done and tx_err SHALL never both be 1 on the same cycle.
REQ-014 Each of tx_done and tx_err SHALL be exactly one cycle long.
REQ-015 tx_valid held high during a transfer SHALL have no effect until tx_ready=1 again.
REQ-016 Changes to tx_data after acceptance SHALL have no effect on the byte in flight.

Reset
REQ-017 While rst=0, on every clock the outputs SHALL be tx_ready=0, tx_done=0, tx_err=0, ps2_clk_oe=0 and ps2_data_oe=0; the state SHALL be IDLE and all counters SHALL be 0.
REQ-018 Reset asserted mid-transfer SHALL release both lines on the next clock edge, with no tx_done or tx_err pulse.
REQ-019 tx_ready SHALL become 1 on the first clock after rst returns to 1.

Configuration
REQ-020 With PS2_TX_TIMEOUT_EN defined, a counter SHALL start on entry to RTS.
REQ-021 With PS2_TX_TIMEOUT_EN defined, if the counter reaches CLK_HZ/1_000_000*TIMEOUT_US before ACK completes, the block SHALL:
- release both lines,
- pulse tx_err,
- move the state directly to IDLE.
REQ-022 With PS2_TX_TIMEOUT_EN undefined, the timeout counter SHALL be absent; RTS, SHIFT and ACK SHALL wait indefinitely, and tx_err SHALL come only from a NACK.

Structure
REQ-023 Package ps2_pkg SHALL hold the state enum and the PS2_FRAME_EDGES=11 constant.
REQ-024 Package ps2_pkg SHALL hold the odd-parity function, which the receiver block also uses.
REQ-025 Sub-module ps2_edge_sync SHALL contain the 2-flop synchronizers and the fall detector, so the existing receiver can reuse it.

Verification
REQ-026 The bench SHALL cover the following directed scenarios, one per line (stimulus -> required response). In all of them CLK_HZ=1_000_000, giving a 100-cycle inhibit, and the device model clocks at a period of 40 cycles.
- Send 0xED with the device ACKing -> ps2_clk_oe high for 100 cycles; data-line bits 1,0,1,1,0,1,1,1, then parity 1 and stop; tx_done one cycle.
- Send 0x00 -> parity bit 1; send 0x01 -> parity bit 0; tx_done after each.
- Device holds data high on edge 11 (NACK) -> tx_err one cycle, tx_done stays 0; return to IDLE after both lines are high.
- With PS2_TX_TIMEOUT_EN and the device silent after RTS -> tx_err 15000 cycles after RTS entry; both oe=0; tx_ready=1 on the next cycle.
- rst=0 after edge 5 -> both oe=0 on the next clock; no pulses; after rst=1, a new 0xF4 transfer completes normally.
- tx_valid=1 in IDLE on the same cycle as a device-generated fall -> byte accepted and fall ignored; tx_valid held high through the transfer -> only one byte sent.
